// File: rtl/compressor_pkg.sv
// ---------------------------------------------------------------------------
// compressor_pkg
// Shared definitions for the sequential popcount block and its 15:4
// compressor: slice/count widths, the controller state type and a helper
// that sizes the slice index counter.
// ---------------------------------------------------------------------------
package compressor_pkg;

    localparam int SLICE_W = 15;   // bits per compressor input slice
    localparam int COUNT_W = 4;    // bits of compressor count output

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a counter able to index n slices; never narrower than 1 bit.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/compressor_15x4.sv
// ---------------------------------------------------------------------------
// compressor_15x4
// Counts the ones among 15 input bits and presents the result as a 4-bit
// binary number split over four single-bit outputs.
// Ports:
//   in_bits  [14:0]  bits to be counted (bit j = input j)
//   out_0..out_3     count, out_0 = LSB, out_3 = MSB
// ---------------------------------------------------------------------------
module compressor_15x4
    import compressor_pkg::*;
(
    input  logic [SLICE_W-1:0] in_bits,
    output logic               out_0,
    output logic               out_1,
    output logic               out_2,
    output logic               out_3
);

    logic [COUNT_W-1:0] w_sum;

    // Add the 15 input bits; 15 fits in 4 bits so the sum cannot overflow.
    always_comb begin
        w_sum = {COUNT_W{1'b0}};
        for (int j = 0; j < SLICE_W; j++) begin
            w_sum = w_sum + {{(COUNT_W-1){1'b0}}, in_bits[j]};
        end
    end

    assign out_0 = w_sum[0];
    assign out_1 = w_sum[1];
    assign out_2 = w_sum[2];
    assign out_3 = w_sum[3];

endmodule

// File: rtl/compressor_popcount_seq.sv
// ---------------------------------------------------------------------------
// compressor_popcount_seq
// Sequential population count of a NSLICES*15-bit word. An accepted word is
// latched, then one 15-bit slice per cycle is fed through a single shared
// compressor_15x4 and summed into an accumulator. The result is offered with
// a valid/ready handshake and can be cancelled with a synchronous abort.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (ready only while idle)
//   in_data               word to count; slice k = bits [15k+14:15k]
//   abort                 cancel a running or completed job
//   out_valid / out_ready result handshake
//   out_count             number of ones (0 whenever out_valid is low)
//   busy                  job running or result pending
// ---------------------------------------------------------------------------
module compressor_popcount_seq
    import compressor_pkg::*;
#(
    parameter int NSLICES = 4,
    parameter int ACC_W   = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SLICE_W*NSLICES-1:0] in_data,
    input  logic                       abort,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           out_count,
    output logic                       busy
);

    localparam int DATA_W = SLICE_W * NSLICES;
    localparam int IDX_W  = idx_width(NSLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

    state_t               r_state;
    logic [IDX_W-1:0]     r_slice_idx;
    logic [DATA_W-1:0]    r_slice;
    logic [ACC_W-1:0]     r_acc;
    logic [ACC_W-1:0]     r_out_count;
    logic                 r_out_valid;
    logic                 r_in_ready;
    logic                 r_busy;

    logic [SLICE_W-1:0]   w_slice;
    logic                 w_out_0;
    logic                 w_out_1;
    logic                 w_out_2;
    logic                 w_out_3;
    logic [COUNT_W-1:0]   w_count;
    logic [ACC_W-1:0]     w_acc_sum;

    // Select the slice addressed by the slice index from the latched word.
    always_comb begin
        w_slice = {SLICE_W{1'b0}};
        for (int k = 0; k < NSLICES; k++) begin
            if (r_slice_idx == IDX_W'(k)) begin
                w_slice = r_slice[k*SLICE_W +: SLICE_W];
            end else begin
                w_slice = w_slice;
            end
        end
    end

    compressor_15x4 u_compressor (
        .in_bits (w_slice),
        .out_0   (w_out_0),
        .out_1   (w_out_1),
        .out_2   (w_out_2),
        .out_3   (w_out_3)
    );

    assign w_count   = {w_out_3, w_out_2, w_out_1, w_out_0};
    // ACC_W is sized so that the full-word maximum never wraps.
    assign w_acc_sum = r_acc + ACC_W'(w_count);

    // Controller: accept, per-slice accumulation, result hold and abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_slice_idx <= {IDX_W{1'b0}};
            r_slice     <= {DATA_W{1'b0}};
            r_acc       <= {ACC_W{1'b0}};
            r_out_count <= {ACC_W{1'b0}};
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // abort is deliberately not looked at while idle
                    if (in_valid && r_in_ready) begin
                        r_slice     <= in_data;
                        r_acc       <= {ACC_W{1'b0}};
                        r_slice_idx <= {IDX_W{1'b0}};
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_RUN;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_acc       <= {ACC_W{1'b0}};
                        r_slice_idx <= {IDX_W{1'b0}};
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (r_slice_idx == LAST_IDX) begin
                        // Final slice: publish the completed sum directly.
                        r_acc       <= w_acc_sum;
                        r_out_count <= w_acc_sum;
                        r_out_valid <= 1'b1;
                        r_slice_idx <= {IDX_W{1'b0}};
                        r_state     <= ST_DONE;
                    end else begin
                        r_acc       <= w_acc_sum;
                        r_slice_idx <= r_slice_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    // abort and delivery leave the same way; abort simply
                    // means the result is treated as not delivered.
                    if (abort || out_ready) begin
                        r_acc       <= {ACC_W{1'b0}};
                        r_out_count <= {ACC_W{1'b0}};
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state     <= ST_DONE;
                    end
                end
                default: begin
                    r_slice_idx <= {IDX_W{1'b0}};
                    r_acc       <= {ACC_W{1'b0}};
                    r_out_count <= {ACC_W{1'b0}};
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_count = r_out_count;
    assign busy      = r_busy;

endmodule

// File: tb/tb_compressor_popcount_seq.sv
// ---------------------------------------------------------------------------
// tb_compressor_popcount_seq
// Self-checking bench: directed vector table, abort/reset/stall sequences,
// randomized jobs and a back-to-back stream, all checked against a
// popcount reference computed with $countones.
// ---------------------------------------------------------------------------
module tb_compressor_popcount_seq;

    localparam int NS = 4;
    localparam int AW = 6;
    localparam int DW = 15 * NS;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_count;
    logic          busy;

    int n_tests;
    int n_fail;

    compressor_popcount_seq #(.NSLICES(NS), .ACC_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            stall;
        bit            abort_idle;
        int            exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_count(input logic [DW-1:0] d);
        return $countones(d);
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [63:0] t;
        logic [63:0] m;
        t = {$urandom(), $urandom()};
        m = {$urandom(), $urandom()};
        // Mix dense and sparse words to spread the count range.
        case ($urandom_range(0, 2))
            0:       t = t & m;
            1:       t = t | m;
            default: t = t;
        endcase
        return t[DW-1:0];
    endfunction

    // One complete job: accept at the next edge, fixed latency, optional stall.
    task automatic do_job(input logic [DW-1:0] data, input int stall,
                          input bit abort_idle, input int exp);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = data;
        abort    = abort_idle;
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
        in_data  = rand_word();
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_in_ready", 64'(in_ready), 64'd0);
        check("run_valid", 64'(out_valid), 64'd0);
        for (int k = 1; k < NS; k++) begin
            @(negedge clk);
            check("run_valid", 64'(out_valid), 64'd0);
            check("run_count", 64'(out_count), 64'd0);
        end
        @(negedge clk);
        check("done_valid", 64'(out_valid), 64'd1);
        check("done_count", 64'(out_count), 64'(exp));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_count", 64'(out_count), 64'(exp));
            check("stall_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", 64'(out_valid), 64'd0);
        check("release_count", 64'(out_count), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
        check("release_busy", 64'(busy), 64'd0);
    endtask

    task automatic watch_no_valid(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int q[$];
        int acc_cyc[$];
        int cyc;
        int got;
        logic [DW-1:0] d;

        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        in_data   = {DW{1'b0}};

        vecs[0] = '{60'hFFF_FFFF_FFFF_FFFF, 0, 1'b0, 60};
        vecs[1] = '{60'h000_0000_0000_0000, 0, 1'b0, 0};
        vecs[2] = '{60'hAAA_AAAA_AAAA_AAAA, 0, 1'b0, 30};
        vecs[3] = '{60'hFFF_FFFF_FFFF_FFFF, 3, 1'b0, 60};
        vecs[4] = '{60'h000_0000_0000_0001, 1, 1'b0, 1};
        vecs[5] = '{60'h000_0000_0000_7FFF, 0, 1'b0, 15};
        vecs[6] = '{60'h800_0000_0000_0000, 2, 1'b1, 1};
        vecs[7] = '{60'h123_4567_89AB_CDEF, 0, 1'b0, 32};

        // Reset values while rst_n is low.
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // Directed table; the first job accepts on the first edge after release.
        for (int i = 0; i < 8; i++) begin
            do_job(vecs[i].data, vecs[i].stall, vecs[i].abort_idle, vecs[i].exp);
        end

        // Abort on the second RUN cycle.
        in_valid = 1'b1;
        in_data  = 60'hFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(out_valid), 64'd0);
        watch_no_valid("abort_no_valid", 8);
        do_job(60'h000_0000_0000_0001, 0, 1'b0, 1);

        // Abort together with out_ready in DONE: abort wins, state returns idle.
        in_valid = 1'b1;
        in_data  = 60'hAAA_AAAA_AAAA_AAAA;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (NS) @(negedge clk);
        check("done_abort_pre_valid", 64'(out_valid), 64'd1);
        check("done_abort_pre_count", 64'(out_count), 64'd30);
        abort     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        out_ready = 1'b0;
        check("done_abort_valid", 64'(out_valid), 64'd0);
        check("done_abort_in_ready", 64'(in_ready), 64'd1);
        check("done_abort_count", 64'(out_count), 64'd0);

        // Reset pulsed mid-RUN.
        in_valid = 1'b1;
        in_data  = 60'hFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_count", 64'(out_count), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("midrst_hold_busy", 64'(busy), 64'd0);
        check("midrst_hold_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        watch_no_valid("midrst_no_valid", 8);
        check("midrst_after_in_ready", 64'(in_ready), 64'd1);

        // Randomized jobs.
        for (int r = 0; r < 20; r++) begin
            d = rand_word();
            do_job(d, $urandom_range(0, 3), 1'b0, ref_count(d));
        end

        // Back-to-back stream with out_ready tied high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = rand_word();
        cyc = 0;
        got = 0;
        while (got < 8 && cyc < 200) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("b2b_unexpected_result", 64'(out_valid), 64'd0);
                end else begin
                    check("b2b_count", 64'(out_count), 64'(q.pop_front()));
                end
                got++;
            end
            if (in_ready) begin
                q.push_back(ref_count(in_data));
                acc_cyc.push_back(cyc);
            end
            @(negedge clk);
            cyc++;
            in_data = rand_word();
        end
        in_valid  = 1'b0;
        check("b2b_results", 64'(got), 64'd8);
        for (int i = 1; i < acc_cyc.size() && i < 8; i++) begin
            check("b2b_period", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(NS + 2));
        end
        repeat (NS + 2) @(negedge clk);
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/compressor_popcount_seq.md
COMPRESSOR_POPCOUNT_SEQ -- requirements
Module: compressor_popcount_seq

Interface
REQ-001 Parameter: NSLICES, default 4, number of 15-bit slices per input word (legal 1..8).
REQ-002 Parameter: ACC_W, default 6, accumulator/result width; SHALL satisfy 2**ACC_W > 15*NSLICES.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  input word offered.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 in_data  input  15*NSLICES  word to popcount; slice k = bits [15k+14:15k].
REQ-008 abort  input  1  synchronous cancel of current job.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 out_count  output  ACC_W  number of ones in accepted word.
REQ-012 busy  output  1  high in RUN or DONE.

Function
REQ-013 FSM states: IDLE, RUN, DONE; only legal encodings reachable.
REQ-014 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready.
REQ-015 On accept: latch in_data into slice register, clear acc to 0, slice_idx := 0, go RUN.
REQ-016 In RUN, each cycle: slice slice_idx drives the 15 inputs of one compressor_15x4 instance (input bit j = slice bit j); acc := acc + zero-extended 4-bit count (out_0 = LSB, out_3 = MSB); slice_idx increments.
REQ-017 After adding slice NSLICES-1, go DONE; out_valid SHALL rise exactly NSLICES cycles after the accept edge.
REQ-018 In DONE: out_valid=1, out_count=acc held stable until out_valid & out_ready; then IDLE next edge, in_ready=1 that cycle.
REQ-019 out_ready low SHALL stall indefinitely in DONE with out_count unchanged.
REQ-020 out_count SHALL be 0 whenever out_valid=0.
REQ-021 abort in RUN or DONE: next state IDLE, acc cleared, result discarded, no out_valid pulse; abort in IDLE ignored.
REQ-022 abort and out_ready both high in DONE: abort wins (result counts as not delivered).
REQ-023 in_data changes after accept SHALL NOT affect the result.
REQ-024 Accumulator SHALL never wrap: max 15*NSLICES fits ACC_W by REQ-002.
REQ-025 Single compressor_15x4 instance shared across all slices; no combinational path in_data -> out_count.

Reset
REQ-026 rst_n low: state IDLE, acc 0, slice_idx 0, slice register 0, out_valid 0, out_count 0, busy 0, in_ready 1 (after release).
REQ-027 Reset asserted mid-RUN or mid-DONE SHALL drop the job immediately with no out_valid afterward.
REQ-028 First accept possible on first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package compressor_pkg: SLICE_W=15, COUNT_W=4, state typedef (IDLE/RUN/DONE).
REQ-030 One sub-module: existing compressor_15x4, instantiated once, unchanged.
REQ-031 Top holds FSM, slice_idx counter (clog2(NSLICES) bits, min 1), slice register, accumulator.

Verification
REQ-032 NSLICES=4, in_data all ones (60'hFFF_FFFF_FFFF_FFFF) -> out_valid 4 cycles after accept, out_count=60.
REQ-033 in_data=0 -> out_count=0; in_data=60'hAAA_AAAA_AAAA_AAAA -> out_count=30.
REQ-034 out_ready held low 3 cycles in DONE -> out_valid and out_count=60 stable all 3 cycles; in_ready=0 throughout; IDLE one edge after out_ready=1.
REQ-035 abort on second RUN cycle -> IDLE next edge, in_ready=1, out_valid never asserts; next word 60'h1 -> out_count=1.
REQ-036 rst_n pulsed low mid-RUN -> all outputs at reset values while low; no out_valid after release.
REQ-037 Back-to-back words with out_ready tied 1 -> one result per NSLICES+2 cycles, counts match reference popcount.
